// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for a NUM_ROWS x NUM_COLS pixel array: erase/expose/convert, row readout, word stream.
// Define PIXEL_CTRL_GRAY_EN for a Gray-coded ADC ramp with Gray-to-binary decode of captured words.
module pixel_array_ctrl #(
    parameter int DATA_W    = 8,
    parameter int NUM_ROWS  = 2,
    parameter int NUM_COLS  = 2,
    parameter int EXP_W     = 16,
    parameter int ERASE_CYC = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         continuous,
    input  logic [EXP_W-1:0]             exp_cycles,
    output logic                         erase,
    output logic                         expose,
    output logic                         convert,
    output logic [DATA_W-1:0]            ramp_data,
    output logic [NUM_ROWS-1:0]          row_sel,
    input  logic [NUM_COLS*DATA_W-1:0]   col_data,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         busy
);

    localparam int EC_W = $clog2(ERASE_CYC + 1);
    localparam int CW0  = (EXP_W > DATA_W) ? EXP_W : DATA_W;
    localparam int CW   = (CW0 > EC_W) ? CW0 : EC_W;
    localparam int RW   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int CLW  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    localparam logic [CW-1:0]  ERASE_LAST = CW'(ERASE_CYC - 1);
    localparam logic [CW-1:0]  RAMP_LAST  = CW'({DATA_W{1'b1}});
    localparam logic [RW-1:0]  ROW_LAST   = RW'(NUM_ROWS - 1);
    localparam logic [CLW-1:0] COL_LAST   = CLW'(NUM_COLS - 1);
    localparam logic           ONE_COL    = (NUM_COLS == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_LATCH,
        S_STREAM
    } state_t;

    state_t                       state_q;
    logic [CW-1:0]                cnt_q;
    logic [EXP_W-1:0]             exp_q;
    logic [RW-1:0]                row_q;
    logic [CLW-1:0]               col_q;
    logic [NUM_COLS*DATA_W-1:0]   cbuf_q;
    logic                         erase_q;
    logic                         expose_q;
    logic                         convert_q;
    logic [DATA_W-1:0]            ramp_q;
    logic [NUM_ROWS-1:0]          row_sel_q;
    logic [DATA_W-1:0]            out_data_q;
    logic                         out_valid_q;
    logic                         out_last_q;

    logic [CW-1:0]                cnt_d;
    logic [CW-1:0]                exp_last;
    logic [RW-1:0]                row_d;
    logic [CLW-1:0]               col_d;
    logic [NUM_COLS*DATA_W-1:0]   cap_d;
    logic [DATA_W-1:0]            word_d;

    function automatic logic [DATA_W-1:0] ramp_enc(input logic [DATA_W-1:0] n);
`ifdef PIXEL_CTRL_GRAY_EN
        return n ^ (n >> 1);
`else
        return n;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] col_dec(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] b;
        b = w;
`ifdef PIXEL_CTRL_GRAY_EN
        for (int i = DATA_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ w[i];
        end
`endif
        return b;
    endfunction

    assign cnt_d    = cnt_q + 1'b1;
    assign exp_last = CW'(exp_q - 1'b1);
    assign row_d    = row_q + 1'b1;
    assign col_d    = col_q + 1'b1;
    assign word_d   = cbuf_q[col_d*DATA_W +: DATA_W];

    always_comb begin
        cap_d = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            cap_d[c*DATA_W +: DATA_W] = col_dec(col_data[c*DATA_W +: DATA_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            exp_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            cbuf_q      <= '0;
            erase_q     <= 1'b0;
            expose_q    <= 1'b0;
            convert_q   <= 1'b0;
            ramp_q      <= '0;
            row_sel_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        exp_q   <= (exp_cycles == '0) ? EXP_W'(1) : exp_cycles;
                        cnt_q   <= '0;
                        erase_q <= 1'b1;
                        state_q <= S_ERASE;
                    end
                end
                S_ERASE: begin
                    if (cnt_q == ERASE_LAST) begin
                        cnt_q    <= '0;
                        erase_q  <= 1'b0;
                        expose_q <= 1'b1;
                        state_q  <= S_EXPOSE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_EXPOSE: begin
                    if (cnt_q == exp_last) begin
                        cnt_q     <= '0;
                        expose_q  <= 1'b0;
                        convert_q <= 1'b1;
                        ramp_q    <= ramp_enc('0);
                        state_q   <= S_CONVERT;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_CONVERT: begin
                    if (cnt_q == RAMP_LAST) begin
                        cnt_q     <= '0;
                        convert_q <= 1'b0;
                        ramp_q    <= '0;
                        row_q     <= '0;
                        row_sel_q <= NUM_ROWS'(1);
                        state_q   <= S_LATCH;
                    end else begin
                        cnt_q  <= cnt_d;
                        ramp_q <= ramp_enc(cnt_d[DATA_W-1:0]);
                    end
                end
                S_LATCH: begin
                    cbuf_q      <= cap_d;
                    row_sel_q   <= '0;
                    col_q       <= '0;
                    out_valid_q <= 1'b1;
                    out_data_q  <= cap_d[DATA_W-1:0];
                    out_last_q  <= (row_q == ROW_LAST) && ONE_COL;
                    state_q     <= S_STREAM;
                end
                S_STREAM: begin
                    if (out_ready) begin
                        if (col_q == COL_LAST) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_data_q  <= '0;
                            if (row_q == ROW_LAST) begin
                                // continuous is only looked at on the final transfer
                                if (continuous) begin
                                    cnt_q   <= '0;
                                    erase_q <= 1'b1;
                                    state_q <= S_ERASE;
                                end else begin
                                    state_q <= S_IDLE;
                                end
                            end else begin
                                row_q     <= row_d;
                                row_sel_q <= NUM_ROWS'(1) << row_d;
                                state_q   <= S_LATCH;
                            end
                        end else begin
                            col_q      <= col_d;
                            out_data_q <= word_d;
                            out_last_q <= (row_q == ROW_LAST) && (col_d == COL_LAST);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign erase     = erase_q;
    assign expose    = expose_q;
    assign convert   = convert_q;
    assign ramp_data = ramp_q;
    assign row_sel   = row_sel_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Randomized bench for pixel_array_ctrl against a phase-timeline reference model.
// The bench emulates the pixel array: it drives col_data from its own pixel table when a row is selected.
module tb_pixel_array_ctrl;

    localparam int DW   = 8;
    localparam int NR   = 2;
    localparam int NC   = 2;
    localparam int EW   = 16;
    localparam int EC   = 2;
    localparam int RAMP = 1 << DW;

    logic              clk;
    logic              reset;
    logic              start;
    logic              continuous;
    logic [EW-1:0]     exp_cycles;
    logic              erase;
    logic              expose;
    logic              convert;
    logic [DW-1:0]     ramp_data;
    logic [NR-1:0]     row_sel;
    logic [NC*DW-1:0]  col_data;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;

    logic [DW-1:0]     pix [NR][NC];
    logic [NC*DW-1:0]  noise;

    int nvec = 0;
    int nerr = 0;

    pixel_array_ctrl #(
        .DATA_W(DW), .NUM_ROWS(NR), .NUM_COLS(NC), .EXP_W(EW), .ERASE_CYC(EC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .exp_cycles(exp_cycles), .erase(erase), .expose(expose), .convert(convert),
        .ramp_data(ramp_data), .row_sel(row_sel), .col_data(col_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pixel array model: selected row drives the column buses, otherwise junk
    always_comb begin
        col_data = noise;
        for (int r = 0; r < NR; r++) begin
            if (row_sel == (NR'(1) << r)) begin
                for (int c = 0; c < NC; c++) begin
                    col_data[c*DW +: DW] = pix[r][c];
                end
            end
        end
    end

    function automatic logic [DW-1:0] ramp_exp(input int n);
        logic [DW-1:0] v;
        v = DW'(n);
`ifdef PIXEL_CTRL_GRAY_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    function automatic logic [DW-1:0] word_exp(input logic [DW-1:0] g);
        logic [DW-1:0] b;
        b = g;
`ifdef PIXEL_CTRL_GRAY_EN
        for (int s = 1; s < DW; s++) b = b ^ (g >> s);
`endif
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        noise = NC*DW'($urandom);
    endtask

    function automatic bit pick_ready(input int mode, input int idx);
        bit pat [6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        case (mode)
            0:       return 1'b1;
            1:       return pat[idx % 6];
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // One frame: timeline of strobes/ramp, then row-major words with handshake.
    task automatic run_frame(input int e_in, input int rmode, input bit chained,
                             input bit cont_end, output int bcnt);
        int e, c, k, idx;
        bit rdy;
        e = (e_in == 0) ? 1 : e_in;
        bcnt = 0;
        idx = 0;
        continuous = cont_end;
        for (int r = 0; r < NR; r++)
            for (int cc = 0; cc < NC; cc++) pix[r][cc] = DW'($urandom);
        if (!chained) begin
            start = 1'b1;
            exp_cycles = EW'(e_in);
            step();
            start = 1'b0;
        end
        exp_cycles = EW'($urandom);
        for (int t = 1; t <= EC + e + RAMP; t++) begin
            logic [2:0] s;
            s = (t <= EC) ? 3'b100 : (t <= EC + e) ? 3'b010 : 3'b001;
            chk("strobe", {erase, expose, convert}, s);
            chk("ramp", ramp_data, (t > EC + e) ? ramp_exp(t - EC - e - 1) : '0);
            chk("quiet", {row_sel, out_valid, busy}, 1);
            if (busy) bcnt++;
            start = ($urandom_range(0, 7) == 0);
            step();
        end
        for (int r = 0; r < NR; r++) begin
            chk("row_sel", row_sel, NR'(1) << r);
            chk("latch_quiet", {erase, expose, convert, out_valid, ramp_data}, 0);
            if (busy) bcnt++;
            step();
            c = 0;
            k = 0;
            while (c < NC && k < 500) begin
                chk("valid", out_valid, 1);
                chk("data", out_data, word_exp(pix[r][c]));
                chk("last", out_last, (r == NR - 1) && (c == NC - 1));
                chk("stream_quiet", {row_sel, erase, expose, convert}, 0);
                if (busy) bcnt++;
                rdy = pick_ready(rmode, idx);
                out_ready = rdy;
                start = ($urandom_range(0, 7) == 0);
                step();
                if (rdy) c++;
                k++;
                idx++;
            end
            if (k >= 500) chk("stream_timeout", 0, 1);
        end
        start = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        if (cont_end)
            chk("cont_restart", {erase, busy, out_valid}, 3'b110);
        else
            chk("end_idle", {busy, erase, expose, convert, out_valid, row_sel}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int b, e, bad;
        reset = 1'b1;
        start = 1'b0;
        continuous = 1'b0;
        exp_cycles = '0;
        out_ready = 1'b0;
        noise = '0;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) pix[r][c] = '0;
        step();
        step();
        chk("reset", {erase, expose, convert, ramp_data, row_sel, out_data,
                      out_valid, out_last, busy}, 0);
        reset = 1'b0;
        step();

        run_frame(5, 0, 1'b0, 1'b0, b);
        chk("latency", b, EC + 5 + RAMP + NR * (NC + 1));
        run_frame(3, 1, 1'b0, 1'b0, b);
        run_frame(0, 2, 1'b0, 1'b0, b);
        run_frame(0, 0, 1'b0, 1'b0, b);
        chk("latency_e0", b, EC + 1 + RAMP + NR * (NC + 1));

        e = $urandom_range(1, 20);
        run_frame(e, 0, 1'b0, 1'b1, b);
        run_frame(e, 2, 1'b1, 1'b0, b);

        start = 1'b1;
        exp_cycles = EW'(5);
        step();
        start = 1'b0;
        for (int i = 0; i < EC + 1; i++) step();
        chk("pre_reset_expose", expose, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_reset", {erase, expose, convert, ramp_data, row_sel, out_data,
                          out_valid, out_last, busy}, 0);
        out_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            if (erase || expose || convert || out_valid || busy || (row_sel != '0)) bad++;
            step();
        end
        chk("post_reset_quiet", bad, 0);

        for (int i = 0; i < 3; i++) begin
            run_frame($urandom_range(0, 12), $urandom_range(0, 2), 1'b0, 1'b0, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pixel_array_ctrl.md
# pixel_array_ctrl

Parametrised frame sequencer for the pixel sensor array, generalising the fixed 2x2, 8-bit pixel top into a configurable NUM_ROWS x NUM_COLS, DATA_W-bit array. It drives the erase/expose/convert phase strobes and the digital ADC ramp shared by all pixels. It reads the array row by row and streams pixel words out over a valid/ready interface. The block sits between the pixel array and the downstream image pipeline.

## Interface
- DATA_W, 8, pixel/ADC resolution in bits; ramp period is 2^DATA_W cycles
- NUM_ROWS, 2, array rows; row_sel width
- NUM_COLS, 2, array columns; words per row
- EXP_W, 16, width of exposure-length input
- ERASE_CYC, 2, cycles erase is held high
- clk  in  1  single system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- continuous  in  1  restart a frame automatically after readout
- exp_cycles  in  EXP_W  exposure length in cycles; latched on accepted start; 0 treated as 1
- erase  out  1  pixel erase strobe
- expose  out  1  pixel expose strobe
- convert  out  1  ADC convert strobe
- ramp_data  out  DATA_W  digital ramp driven to pixel comparators/latches
- row_sel  out  NUM_ROWS  one-hot row read enable
- col_data  in  NUM_COLS*DATA_W  column buses; column c at [c*DATA_W +: DATA_W]
- out_data  out  DATA_W  pixel word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts word
- out_last  out  1  qualifies final word of frame
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ERASE, EXPOSE, CONVERT, LATCH, STREAM.
- IDLE: start=1 latches exp_cycles -> ERASE.
- ERASE: erase=1 for ERASE_CYC cycles -> EXPOSE.
- EXPOSE: expose=1 for max(exp_cycles,1) cycles -> CONVERT.
- CONVERT: convert=1 for 2^DATA_W cycles; internal counter 0..2^DATA_W-1, +1 per cycle, no wrap inside phase. Then row index=0 -> LATCH.
- LATCH: row_sel[row]=1 for exactly one cycle; col_data captured into column buffer at end of that cycle -> STREAM, col index=0.
- STREAM: out_valid=1, out_data=buffer[col]. On out_valid&&out_ready: col+1. After col NUM_COLS-1 transfers: next row -> LATCH, or after last row -> ERASE if continuous=1 (sampled on final transfer), else IDLE.
- Order: row 0 col 0 first, column then row ascending.
- out_last=1 only with row=NUM_ROWS-1, col=NUM_COLS-1.
- start outside IDLE is ignored; exp_cycles changes mid-frame have no effect.
- ramp_data=0 outside CONVERT. erase/expose/convert/row_sel are mutually exclusive.

## Timing
- Reset: all outputs 0, FSM IDLE, counters 0, on the first edge with reset=1; mid-frame reset aborts with no further strobes or words.
- start sampled at edge k: erase high cycles k+1..k+ERASE_CYC; expose follows with no gap; convert follows with no gap.
- ramp_data=0 in first convert cycle, 2^DATA_W-1 in last.
- LATCH to first out_valid: 1 cycle. With out_ready held 1: one word per cycle, plus one LATCH bubble per row.
- Frame latency at out_ready=1: ERASE_CYC + E + 2^DATA_W + NUM_ROWS*(NUM_COLS+1) cycles, with E = max(exp_cycles,1).
- Handshake: out_data/out_last stable while out_valid&&!out_ready; out_valid never drops without a transfer except on reset.

## Configuration
- PIXEL_CTRL_GRAY_EN defined: ramp_data = counter ^ (counter>>1), Gray coded. Each captured column word is Gray-to-binary converted before out_data.
- Undefined: ramp_data = binary counter; col_data passed through unchanged.

## Test plan
- Reset mid-EXPOSE, held 1 cycle -> next cycle all outputs 0, busy=0; no words emitted afterwards.
- Defaults, exp_cycles=5, start pulse, out_ready=1 -> erase 2 cycles, expose 5, convert 256 with ramp 0..255. Then 4 words in order col_data row0 c0,c1, row1 c0,c1; out_last on 4th; total 2+5+256+6 cycles.
- Backpressure: out_ready pattern 1,0,0,1,0,1 -> no word lost or duplicated, out_data stable while stalled.
- exp_cycles=0 -> expose high exactly 1 cycle; start asserted during CONVERT ignored.
- continuous=1 -> erase rises the cycle after the final transfer; clear continuous -> IDLE after that frame.
- PIXEL_CTRL_GRAY_EN: ramp 0,1,3,2,6...; col_data word 0x77 -> out_data 0x5A.
